// File: rtl/uart_tx_periph_if.sv
// ----------------------------------------------------------------------------
// uart_tx_periph_if
// Data-bus connection between the core and the UART transmitter peripheral.
//   data_in  [31:0]  store data from the core (bus_b)
//   addr     [31:0]  byte address (alu_res); the peripheral decodes addr[3:2]
//   we               one-cycle write strobe for this peripheral
//   data_out [31:0]  read data returned to the core's load mux
// master = core side, slave = peripheral side.
// ----------------------------------------------------------------------------
interface uart_tx_periph_if;
    logic [31:0] data_in;
    logic [31:0] addr;
    logic        we;
    logic [31:0] data_out;

    modport master (
        output data_in,
        output addr,
        output we,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  addr,
        input  we,
        output data_out
    );
endinterface

// File: rtl/uart_tx_periph.sv
// ----------------------------------------------------------------------------
// uart_tx_periph
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA are queued in a small
// FIFO so software is decoupled from the serial bit rate; frames are sent
// back-to-back while the FIFO holds data.
//
// Ports
//   clk        core clock, all logic on the rising edge
//   arst_n     reset, synchronous, active-low
//   bus        slave side of uart_tx_periph_if (data_in, addr, we, data_out)
//   tx         serial output, registered, idles high
//   irq_empty  high when the FIFO is empty and no frame is in progress
//
// Register map (addr[3:2])
//   0 TXDATA  W: queue data_in[7:0]        R: 0
//   1 STATUS  R: {24'b0, count[3:0], ovf, busy, empty, full}
//             W: data_in[3]=1 clears the sticky overflow flag
//   2,3       R: 0                          W: ignored
// ----------------------------------------------------------------------------
module uart_tx_periph #(
    parameter int CLK_DIV    = 29,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            arst_n,
    uart_tx_periph_if.slave bus,
    output logic            tx,
    output logic            irq_empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BAUD_MAX  = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             irq_empty_q, irq_empty_d;

    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             ovf_clr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             baud_end;
    logic [7:0]       fifo_head;
    logic [3:0]       count_field;
    logic             unused_bits;

    // Only the byte lane, the ovf-clear bit and addr[3:2] carry meaning.
    assign unused_bits = ^{bus.data_in[31:8], bus.addr[31:4], bus.addr[1:0]};

    assign push_req   = bus.we && (bus.addr[3:2] == 2'd0);
    assign ovf_clr    = bus.we && (bus.addr[3:2] == 2'd1) && bus.data_in[3];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign baud_end   = (baud_q == BAUD_MAX);

    // ------------------------------------------------------------------
    // Transmit FSM. tx_d is the line level for the state being entered,
    // so every level is held for exactly CLK_DIV cycles after the edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        // Next bit is the one that becomes shift[0] after the shift.
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping. A pop in the same cycle frees a slot, so a push
    // to a full FIFO is still accepted when the FSM is popping.
    // ------------------------------------------------------------------
    always_comb begin
        push_ok  = push_req && (!fifo_full || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end

        irq_empty_d = (count_d == '0) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            baud_q      <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            tx_q        <= 1'b1;
            irq_empty_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            baud_q      <= baud_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            irq_empty_q <= irq_empty_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (arst_n && push_ok) begin
            fifo_mem[wr_ptr_q] <= bus.data_in[7:0];
        end
    end

    // STATUS count field is always 4 bits wide.
    assign count_field = 4'(count_q);

    always_comb begin
        bus.data_out = 32'h0;
        if (bus.addr[3:2] == 2'd1) begin
            bus.data_out = {24'h0, count_field, ovf_q, (state_q != S_IDLE),
                            fifo_empty, fifo_full};
        end
    end

    assign tx        = tx_q;
    assign irq_empty = irq_empty_q;
endmodule

// File: tb/tb_uart_tx_periph.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_periph
// Bench for uart_tx_periph with CLK_DIV=4, FIFO_DEPTH=4. Bytes accepted by
// the FIFO are pushed onto a scoreboard queue when stored; a serial receiver
// on tx decodes each frame and pops/compares against the queue. STATUS is
// checked from a vector table for the FIFO fill/overflow sequence and by
// hand-written sequences for frame timing, back-to-back frames, the
// full-FIFO push/pop collision and reset mid-frame.
// ----------------------------------------------------------------------------
module tb_uart_tx_periph;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic tx;
    logic irq_empty;

    uart_tx_periph_if bus_if ();

    uart_tx_periph #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .bus      (bus_if.slave),
        .tx       (tx),
        .irq_empty(irq_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] sb_q[$];
    int         start_times[$];
    logic       rx_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- serial receiver / scoreboard ----------------
    initial begin
        int         rx_cyc;
        int         b;
        logic [7:0] rx_byte;
        logic [7:0] exp_byte;
        rx_cyc  = 0;
        rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                rx_busy = 1'b0;
            end else if (!rx_busy) begin
                if (tx === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_cyc  = 0;
                    start_times.push_back(cyc);
                end
            end else begin
                rx_cyc++;
            end
            if (rx_busy && arst_n && (rx_cyc % CLK_DIV) == CLK_DIV / 2) begin
                b = rx_cyc / CLK_DIV;
                if (b == 0) begin
                    check("rx_start_bit", {31'h0, tx}, 32'h0);
                end else if (b <= 8) begin
                    rx_byte[b-1] = tx;
                end else begin
                    check("rx_stop_bit", {31'h0, tx}, 32'h1);
                    if (sb_q.size() == 0) begin
                        check("rx_unexpected_frame", {24'h0, rx_byte}, 32'hFFFF_FFFF);
                    end else begin
                        exp_byte = sb_q.pop_front();
                        $display("rx frame byte=%h expected=%h", rx_byte, exp_byte);
                        check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_byte});
                    end
                    rx_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- bus helpers (called ~1ns after a posedge) ----------------
    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        bus_if.addr    = {28'h0, a};
        bus_if.data_in = {24'h0, d};
        bus_if.we      = 1'b1;
        @(posedge clk);
        #1;
        bus_if.we = 1'b0;
        $display("write addr=%h data=%h cyc=%0d", a, d, cyc);
    endtask

    task automatic idle_cycle();
        bus_if.we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
        bus_if.we   = 1'b0;
        bus_if.addr = {28'h0, a};
        #1;
        d = bus_if.data_out;
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && irq_empty === 1'b1 && !rx_busy) && n < max_cyc) begin
            idle_cycle();
            n++;
        end
        check(name, {31'h0, (n < max_cyc)}, 32'h1);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic        sent;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] rd;
        logic [9:0]  frame;
        int          k;

        // FIFO fill / overflow / ovf-clear table, applied on consecutive edges
        vecs[0] = '{4'h0, 8'h11, 1'b1, 32'h10};
        vecs[1] = '{4'h0, 8'h22, 1'b1, 32'h14};
        vecs[2] = '{4'h0, 8'h33, 1'b1, 32'h24};
        vecs[3] = '{4'h0, 8'h44, 1'b1, 32'h34};
        vecs[4] = '{4'h0, 8'h55, 1'b1, 32'h45};
        vecs[5] = '{4'h0, 8'h66, 1'b0, 32'h4D};
        vecs[6] = '{4'h4, 8'h08, 1'b0, 32'h45};
        vecs[7] = '{4'h8, 8'hFF, 1'b0, 32'h45};

        bus_if.we      = 1'b0;
        bus_if.addr    = 32'h0;
        bus_if.data_in = 32'h0;

        // ---- 1: reset held for two edges ----
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        check("reset_tx", {31'h0, tx}, 32'h1);
        check("reset_irq_empty", {31'h0, irq_empty}, 32'h1);
        read_reg(4'h4, rd);
        check("reset_status", rd, 32'h02);
        read_reg(4'h0, rd);
        check("read_txdata_zero", rd, 32'h0);
        read_reg(4'hC, rd);
        check("read_addr_c_zero", rd, 32'h0);

        // ---- 2: single 0x55 frame, level checked every cycle ----
        frame = {1'b1, 8'h55, 1'b0};
        sb_q.push_back(8'h55);
        do_write(4'h0, 8'h55);
        check("t2_irq_after_store", {31'h0, irq_empty}, 32'h0);
        for (int i = 1; i <= 10 * CLK_DIV; i++) begin
            idle_cycle();
            check($sformatf("t2_tx_cyc%0d", i), {31'h0, tx}, {31'h0, frame[(i-1)/CLK_DIV]});
            read_reg(4'h4, rd);
            check($sformatf("t2_busy_cyc%0d", i), {31'h0, rd[2]}, 32'h1);
        end
        idle_cycle();
        read_reg(4'h4, rd);
        check("t2_status_idle", rd, 32'h02);
        check("t2_irq_idle", {31'h0, irq_empty}, 32'h1);
        check("t2_tx_idle", {31'h0, tx}, 32'h1);
        drain("t2_drain", 50);

        // ---- 3: back-to-back frames, no idle gap ----
        start_times.delete();
        sb_q.push_back(8'h01);
        do_write(4'h0, 8'h01);
        sb_q.push_back(8'h02);
        do_write(4'h0, 8'h02);
        drain("t3_drain", 200);
        check("t3_frame_count", start_times.size(), 32'd2);
        if (start_times.size() == 2) begin
            check("t3_start_gap", start_times[1] - start_times[0], 10 * CLK_DIV);
        end

        // ---- 4: fill, overflow, clear ovf (table) ----
        k = 0;
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].sent) sb_q.push_back(vecs[v].wdata);
            do_write(vecs[v].addr, vecs[v].wdata);
            if (v == 0) k = cyc;
            read_reg(4'h4, rd);
            $display("vec %0d addr=%h data=%h status=%h", v, vecs[v].addr, vecs[v].wdata, rd);
            check($sformatf("t4_status_vec%0d", v), rd, vecs[v].exp_status);
        end

        // ---- 5: push into full FIFO on the same edge as the STOP-end pop ----
        while (cyc < k + 10 * CLK_DIV) idle_cycle();
        read_reg(4'h4, rd);
        check("t5_full_before", rd, 32'h45);
        sb_q.push_back(8'h77);
        do_write(4'h0, 8'h77);
        read_reg(4'h4, rd);
        check("t5_status_after_collision", rd, 32'h45);
        drain("t5_drain", 400);
        read_reg(4'h4, rd);
        check("t5_status_drained", rd, 32'h02);

        // ---- 6: reset during DATA bit 3 aborts the frame ----
        sb_q.push_back(8'hA5);
        do_write(4'h0, 8'hA5);
        k = cyc;
        while (cyc < k + 17) idle_cycle();
        check("t6_tx_bit3", {31'h0, tx}, 32'h0);
        arst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        arst_n = 1'b1;
        void'(sb_q.pop_back());
        check("t6_tx_after_reset", {31'h0, tx}, 32'h1);
        check("t6_irq_after_reset", {31'h0, irq_empty}, 32'h1);
        read_reg(4'h4, rd);
        check("t6_status_after_reset", rd, 32'h02);
        @(posedge clk);
        #1;
        start_times.delete();
        sb_q.push_back(8'h3C);
        do_write(4'h0, 8'h3C);
        drain("t6_drain", 60);
        check("t6_frame_count", start_times.size(), 32'd1);

        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
